// File: rtl/shift_seq_pkg.sv
// Shared types for the shift-register sequencer: FSM state encoding and fill-mode codes.
package shift_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StDone,
    StClear
  } state_e;

  localparam logic [1:0] FILL_ZERO  = 2'b00;
  localparam logic [1:0] FILL_ONE   = 2'b01;
  localparam logic [1:0] FILL_ARITH = 2'b10;
  localparam logic [1:0] FILL_ROT   = 2'b11;

endpackage

// File: rtl/shift_counter.sv
// Loadable down-counter holding the number of shifts still to issue.
module shift_counter #(
  parameter int unsigned CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic          dec,
  input  logic [CW-1:0] ld_val,
  output logic [CW-1:0] count,
  output logic          zero_next
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (ld) begin
      count_d = ld_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Flags the value the counter will hold after this edge.
  assign zero_next = (count_d == '0);
  assign count     = count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Command sequencer for a serial shift register: load, N right shifts with a chosen fill,
// then hold done until acknowledged. Abort clears the register and returns to idle.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned N  = 32,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] shamt,
  input  logic [1:0]    mode,
  input  logic          abort,
  input  logic          ack,
  input  logic          sr_msb,
  input  logic          sr_lsb,
  output logic          sr_clr,
  output logic          sr_ld,
  output logic          sr_shf,
  output logic          sr_ser,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] remaining
);

  state_e        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [CW-1:0] shamt_sat;
  logic          cnt_ld, cnt_dec, cnt_zero_next;
  logic [CW-1:0] cnt_val;
  logic          fill;

  assign shamt_sat = (shamt > CW'(N)) ? CW'(N) : shamt;

  shift_counter #(
    .CW(CW)
  ) u_remaining (
    .clk      (clk),
    .rst      (rst),
    .ld       (cnt_ld),
    .dec      (cnt_dec),
    .ld_val   (cnt_val),
    .count    (remaining),
    .zero_next(cnt_zero_next)
  );

  // Counter control depends only on state and inputs, keeping it apart from the
  // next-state logic that consumes zero_next.
  always_comb begin
    cnt_ld  = 1'b0;
    cnt_dec = 1'b0;
    cnt_val = shamt_sat;
    unique case (state_q)
      StIdle: begin
        cnt_ld = start;
      end
      StLoad, StShift, StDone: begin
        if (abort) begin
          cnt_ld  = 1'b1;
          cnt_val = '0;
        end else if (state_q == StShift) begin
          cnt_dec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          mode_d  = mode;
        end
      end
      StLoad: begin
        if (abort) begin
          state_d = StClear;
        end else if (remaining == '0) begin
          state_d = StDone;
        end else begin
          state_d = StShift;
        end
      end
      StShift: begin
        if (abort) begin
          state_d = StClear;
        end else if (cnt_zero_next) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (abort) begin
          state_d = StClear;
        end else if (ack) begin
          state_d = StIdle;
        end
      end
      StClear: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      mode_q  <= FILL_ZERO;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    fill = 1'b0;
    unique case (mode_q)
      FILL_ZERO:  fill = 1'b0;
      FILL_ONE:   fill = 1'b1;
      FILL_ARITH: fill = sr_msb;
      FILL_ROT:   fill = sr_lsb;
      default:    fill = 1'b0;
    endcase
  end

  assign sr_ld  = (state_q == StLoad);
  assign sr_shf = (state_q == StShift);
  assign sr_clr = (state_q == StClear);
  assign done   = (state_q == StDone);
  assign busy   = (state_q != StIdle);
  // Gated so the fill line rests low whenever no shift is happening.
  assign sr_ser = sr_shf & fill;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: drives a modelled 32-bit shift register and checks every cycle
// against a command-level model, plus directed scenarios with literal expectations.
module tb_shift_sequencer;

  localparam int N  = 32;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          ack = 1'b0;
  logic [CW-1:0] shamt = '0;
  logic [1:0]    mode = 2'b00;
  logic          sr_msb, sr_lsb;
  logic          sr_clr, sr_ld, sr_shf, sr_ser, busy, done;
  logic [CW-1:0] remaining;

  logic [31:0] sr = 32'h0;
  logic [31:0] ld_data = 32'h0;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          cmp_en = 1'b0;

  // Command-level model: kind 0 idle, 1 command in flight, 2 clear cycle.
  // m_t is the cycle index since the accepting cycle.
  int         m_kind = 0;
  int         m_t = 0;
  int         m_n = 0;
  logic [1:0] m_mode = 2'b00;

  always #5 clk = ~clk;

  assign sr_msb = sr[31];
  assign sr_lsb = sr[0];

  shift_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .shamt    (shamt),
    .mode     (mode),
    .abort    (abort),
    .ack      (ack),
    .sr_msb   (sr_msb),
    .sr_lsb   (sr_lsb),
    .sr_clr   (sr_clr),
    .sr_ld    (sr_ld),
    .sr_shf   (sr_shf),
    .sr_ser   (sr_ser),
    .busy     (busy),
    .done     (done),
    .remaining(remaining)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sr_clr)      sr <= 32'h0;
    else if (sr_ld)  sr <= ld_data;
    else if (sr_shf) sr <= {sr_ser, sr[31:1]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_kind <= 0;
      m_t    <= 0;
      m_n    <= 0;
      m_mode <= 2'b00;
    end else begin
      case (m_kind)
        0: if (start) begin
          m_kind <= 1;
          m_t    <= 1;
          m_n    <= (int'(shamt) > N) ? N : int'(shamt);
          m_mode <= mode;
        end
        1: begin
          if (abort) m_kind <= 2;
          else if (m_t == m_n + 2) begin
            if (ack) m_kind <= 0;
          end else m_t <= m_t + 1;
        end
        default: m_kind <= 0;
      endcase
    end
  end

  always @(negedge clk) begin : compare
    bit   e_ld, e_shf, e_done, e_clr, e_busy, e_ser;
    int   e_rem;
    if (cmp_en) begin
      e_ld   = (m_kind == 1) && (m_t == 1);
      e_shf  = (m_kind == 1) && (m_t >= 2) && (m_t <= m_n + 1);
      e_done = (m_kind == 1) && (m_t == m_n + 2);
      e_clr  = (m_kind == 2);
      e_busy = (m_kind != 0);
      e_rem  = e_ld ? m_n : (e_shf ? m_n - (m_t - 2) : 0);
      chk("sr_ld", 32'(sr_ld), 32'(e_ld));
      chk("sr_shf", 32'(sr_shf), 32'(e_shf));
      chk("done", 32'(done), 32'(e_done));
      chk("sr_clr", 32'(sr_clr), 32'(e_clr));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("remaining", 32'(remaining), 32'(e_rem));
      if (e_shf) begin
        case (m_mode)
          2'b00:   e_ser = 1'b0;
          2'b01:   e_ser = 1'b1;
          2'b10:   e_ser = sr[31];
          default: e_ser = sr[0];
        endcase
        chk("sr_ser", 32'(sr_ser), 32'(e_ser));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a command from idle and returns the cycle index at which done is first seen.
  task automatic run_cmd(input int sh, input logic [1:0] md, input logic [31:0] data,
                         output int done_cyc);
    shamt   = CW'(sh);
    mode    = md;
    ld_data = data;
    start   = 1'b1;
    tick();
    start    = 1'b0;
    done_cyc = 1;
    while (!done && done_cyc < 100) begin
      tick();
      done_cyc++;
    end
    chk("done_reached", 32'(done), 32'd1);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("idle_after_ack", 32'(busy), 32'd0);
  endtask

  task automatic wait_done_ack();
    int n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk("done_reached", 32'(done), 32'd1);
    do_ack();
  endtask

  initial begin
    int lat;
    repeat (2) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", 32'({sr_clr, sr_ld, sr_shf, sr_ser, done}), 32'd0);
    chk("rst_remaining", 32'(remaining), 32'd0);
    rst    = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Reset asserted in the middle of a shift run.
    shamt = 6'd5;
    mode  = 2'b01;
    ld_data = 32'h0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_rst_shift", 32'(sr_shf), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_outs", 32'({sr_clr, sr_ld, sr_shf, sr_ser, busy, done}), 32'd0);
    chk("midrst_remaining", 32'(remaining), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    run_cmd(3, 2'b00, 32'hF000_000F, lat);
    chk("zero_fill_latency", 32'(lat), 32'd5);
    chk("zero_fill_data", sr, 32'h1E00_0001);
    do_ack();

    run_cmd(4, 2'b11, 32'h0000_000A, lat);
    chk("rotate_latency", 32'(lat), 32'd6);
    chk("rotate_data", sr, 32'hA000_0000);
    do_ack();

    run_cmd(N + 5, 2'b10, 32'h8000_0000, lat);
    chk("arith_sat_latency", 32'(lat), 32'd34);
    chk("arith_data", sr, 32'hFFFF_FFFF);
    do_ack();

    run_cmd(0, 2'b00, 32'h0000_1234, lat);
    chk("zero_count_latency", 32'(lat), 32'd2);
    chk("zero_count_data", sr, 32'h0000_1234);
    tick();
    tick();
    do_ack();
    run_cmd(1, 2'b01, 32'h0, lat);
    chk("b2b_latency", 32'(lat), 32'd3);
    chk("b2b_data", sr, 32'h8000_0000);
    do_ack();

    // Abort in the second shift cycle.
    shamt = 6'd6;
    mode  = 2'b00;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_clr", 32'({sr_clr, done}), 32'b10);
    chk("abort_sr_cleared", sr, 32'h0);
    tick();
    chk("abort_idle", 32'({busy, sr_clr, done}), 32'd0);

    // Abort beats ack in DONE.
    run_cmd(2, 2'b01, 32'h0, lat);
    abort = 1'b1;
    ack   = 1'b1;
    tick();
    abort = 1'b0;
    ack   = 1'b0;
    chk("abort_ack_clr", 32'({sr_clr, done}), 32'b10);
    tick();
    chk("abort_ack_idle", 32'(busy), 32'd0);

    // start and ack during SHIFT are ignored.
    shamt = 6'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    ack   = 1'b1;
    shamt = 6'd1;
    tick();
    start = 1'b0;
    ack   = 1'b0;
    chk("ignored_remaining", 32'(remaining), 32'd3);
    chk("ignored_shf", 32'(sr_shf), 32'd1);
    wait_done_ack();

    // start together with abort in idle is accepted.
    shamt = 6'd2;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", 32'(sr_ld), 32'd1);
    wait_done_ack();

    for (int i = 0; i < 4000; i++) begin
      start   = ($urandom_range(0, 3) == 0);
      shamt   = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 63))
                                            : CW'($urandom_range(0, 8));
      mode    = 2'($urandom_range(0, 3));
      abort   = ($urandom_range(0, 19) == 0);
      ack     = ($urandom_range(0, 2) == 0);
      ld_data = $urandom;
      if ($urandom_range(0, 399) == 0) rst = 1'b0;
      tick();
      rst = 1'b1;
    end
    start  = 1'b0;
    abort  = 1'b0;
    ack    = 1'b0;
    tick();
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
